// File: rtl/alu_control_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_control_pkg - shared ALU op codes, class/func7 encodings, MDU FSM states
// Revision: 1.0
// ----------------------------------------------------------------------------
package alu_control_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_XOR     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_AND     = 4'd4;
  localparam logic [3:0] OP_SLL     = 4'd5;
  localparam logic [3:0] OP_SRL     = 4'd6;
  localparam logic [3:0] OP_SRA     = 4'd7;
  localparam logic [3:0] OP_SLT     = 4'd8;
  localparam logic [3:0] OP_SLTU    = 4'd9;
  localparam logic [3:0] OP_PASS_B  = 4'd10;
  localparam logic [3:0] OP_MDU     = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b010;
  localparam logic [2:0] ALUOP_LUI    = 3'b011;
  localparam logic [2:0] ALUOP_IARITH = 3'b100;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t S_IDLE = 2'd0;
  localparam mdu_state_t S_MUL  = 2'd1;
  localparam mdu_state_t S_DIV  = 2'd2;
  localparam mdu_state_t S_DONE = 2'd3;

  // Default-funct7 mapping shared by R-type and I-arith decode.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    op = OP_ILLEGAL;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_mdu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_iter_core - shift-add multiplier / restoring divider, one bit per step.
// Divider built only with ALU_CONTROL_DIV_EN. Revision: 1.0
// ----------------------------------------------------------------------------
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             op_high,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] result_next
);

  // hi/lo: product accumulator for multiply, remainder/quotient for divide.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] operand;
  logic             high_sel;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH:0]   mul_sum;

`ifdef ALU_CONTROL_DIV_EN
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign a_mag = (op_signed && src_a[WIDTH-1]) ? (WIDTH'(0) - src_a) : src_a;
  assign b_mag = (op_signed && src_b[WIDTH-1]) ? (WIDTH'(0) - src_b) : src_b;
`else
  logic unused_div_cfg;
  assign unused_div_cfg = op_div ^ op_signed;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      operand  <= '0;
      count    <= '0;
      high_sel <= 1'b0;
`ifdef ALU_CONTROL_DIV_EN
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (load) begin
      hi       <= '0;
      count    <= CNT_W'(WIDTH);
      high_sel <= op_high;
`ifdef ALU_CONTROL_DIV_EN
      is_div   <= op_div;
      lo       <= op_div ? a_mag : src_b;
      operand  <= op_div ? b_mag : src_a;
      neg_q    <= op_div && op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r    <= op_div && op_signed && src_a[WIDTH-1];
`else
      lo       <= src_b;
      operand  <= src_a;
`endif
    end else if (step) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count - 1'b1;
    end
  end

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_CONTROL_DIV_EN
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_next = div_diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    result_next = high_sel ? hi_next : lo_next;
`ifdef ALU_CONTROL_DIV_EN
    if (is_div) begin
      if (high_sel) begin
        result_next = neg_r ? (WIDTH'(0) - hi_next) : hi_next;
      end else begin
        result_next = neg_q ? (WIDTH'(0) - lo_next) : lo_next;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_control_mdu - ALU op decode plus stalling RV32M multiply/divide sequencer.
// Define ALU_CONTROL_DIV_EN to build DIV/DIVU/REM/REMU. Revision: 1.0
// ----------------------------------------------------------------------------
module alu_control_mdu
  import alu_control_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       aluop,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       aluoperation,
  output logic             stall,
  output logic             mdu_done,
  output logic [WIDTH-1:0] mdu_result,
  output logic             illegal
);

`ifdef ALU_CONTROL_DIV_EN
  localparam bit DIV_BUILT = 1'b1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam bit DIV_BUILT = 1'b0;
`endif

  mdu_state_t       state;
  mdu_state_t       state_next;
  logic             mdu_func3_ok;
  logic             is_mdu;
  logic             issue;
  logic             busy;
  logic             last_step;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] core_result;

  assign mdu_func3_ok = (func3 == 3'b000) || (func3 == 3'b011) || (DIV_BUILT && func3[2]);

  always_comb begin
    aluoperation = OP_ILLEGAL;
    case (aluop)
      ALUOP_ADD: aluoperation = OP_ADD;
      ALUOP_LUI: aluoperation = OP_PASS_B;
      ALUOP_BRANCH: begin
        case (func3)
          3'b000, 3'b001: aluoperation = OP_SUB;
          3'b100, 3'b101: aluoperation = OP_SLT;
          3'b110, 3'b111: aluoperation = OP_SLTU;
          default:        aluoperation = OP_ILLEGAL;
        endcase
      end
      ALUOP_IARITH: begin
        // Only the shift-immediates carry meaning in funct7.
        case (func3)
          3'b001: begin
            if (func7 == F7_BASE) aluoperation = OP_SLL;
          end
          3'b101: begin
            if (func7 == F7_BASE)     aluoperation = OP_SRL;
            else if (func7 == F7_ALT) aluoperation = OP_SRA;
          end
          default: aluoperation = base_op(func3);
        endcase
      end
      ALUOP_RTYPE: begin
        if (func7 == F7_BASE) begin
          aluoperation = base_op(func3);
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'b000)      aluoperation = OP_SUB;
          else if (func3 == 3'b101) aluoperation = OP_SRA;
        end else if (func7 == F7_MULDIV && mdu_func3_ok) begin
          aluoperation = OP_MDU;
        end
      end
      default: aluoperation = OP_ILLEGAL;
    endcase
  end

  assign illegal = (aluoperation == OP_ILLEGAL);
  assign is_mdu  = (aluoperation == OP_MDU);

`ifdef ALU_CONTROL_DIV_EN
  logic div_zero;
  logic div_ovf;
  assign div_zero = (src_b == '0);
  assign div_ovf  = !func3[0] && (src_a == MOST_NEG) && (src_b == '1);
  // Degenerate divides retire without iterating; func3[1] selects remainder.
  assign special  = func3[2] && (div_zero || div_ovf);
  assign special_result = func3[1] ? (div_zero ? src_a : '0)
                                   : (div_zero ? '1 : src_a);
  assign busy = (state == S_MUL) || (state == S_DIV);
`else
  assign special        = 1'b0;
  assign special_result = '0;
  assign busy           = (state == S_MUL);
`endif

  assign issue     = !reset && (state == S_IDLE) && valid && is_mdu;
  assign last_step = busy && valid && (count == CNT_W'(1));
  assign stall     = issue || busy;
  assign mdu_done  = (state == S_DONE);

  always_comb begin
    state_next = S_IDLE;
    if (state == S_IDLE) begin
      state_next = S_IDLE;
      if (issue) begin
        if (special) begin
          state_next = S_DONE;
`ifdef ALU_CONTROL_DIV_EN
        end else if (func3[2]) begin
          state_next = S_DIV;
`endif
        end else begin
          state_next = S_MUL;
        end
      end
    end else if (busy) begin
      if (!valid)         state_next = S_IDLE;
      else if (last_step) state_next = S_DONE;
      else                state_next = state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mdu_result <= '0;
    end else begin
      state <= state_next;
      if (issue && special) begin
        mdu_result <= special_result;
      end else if (last_step) begin
        mdu_result <= core_result;
      end
    end
  end

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .load        (issue && !special),
    .step        (busy && valid),
    .op_div      (func3[2]),
    .op_signed   (!func3[0]),
    .op_high     (func3[1]),
    .src_a       (src_a),
    .src_b       (src_b),
    .count       (count),
    .result_next (core_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_control_mdu - directed and random checks against a transaction model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_alu_control_mdu;

  localparam int WIDTH = 32;

`ifdef ALU_CONTROL_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  aluop = 3'd0;
  logic [2:0]  func3 = 3'd0;
  logic [6:0]  func7 = 7'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [3:0]  aluoperation;
  logic        stall;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  alu_control_mdu #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .aluop        (aluop),
    .func3        (func3),
    .func7        (func7),
    .src_a        (src_a),
    .src_b        (src_b),
    .aluoperation (aluoperation),
    .stall        (stall),
    .mdu_done     (mdu_done),
    .mdu_result   (mdu_result),
    .illegal      (illegal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mnemonic-level decode: what ALU op each instruction class/encoding means.
  function automatic int exp_op(input logic [2:0] ao, input logic [2:0] f3, input logic [6:0] f7);
    int base [8];
    base = '{0, 5, 8, 9, 2, 6, 3, 4};
    case (ao)
      3'b000: return 0;
      3'b011: return 10;
      3'b010: begin
        if (f3 == 0 || f3 == 1) return 1;
        if (f3 == 4 || f3 == 5) return 8;
        if (f3 >= 6) return 9;
        return 15;
      end
      3'b100: begin
        if (f3 == 1) return (f7 == 0) ? 5 : 15;
        if (f3 == 5) return (f7 == 0) ? 6 : (f7 == 7'h20) ? 7 : 15;
        return base[f3];
      end
      3'b111: begin
        if (f7 == 0) return base[f3];
        if (f7 == 7'h20) return (f3 == 0) ? 1 : (f3 == 5) ? 7 : 15;
        if (f7 == 1) return (f3 == 0 || f3 == 3 || (DIV_ON && f3 >= 4)) ? 14 : 15;
        return 15;
      end
      default: return 15;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f3)
      3'd0: return p[31:0];
      3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      3'd7: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction model: 0 idle, 1 busy (stalling), 2 retiring this cycle.
  int          cyc = 0;
  int          phase = 0;
  int          done_at = 0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] pending = 32'd0;

  always @(negedge clk) begin
    int eop;
    cyc++;
    eop = exp_op(aluop, func3, func7);
    if (started) begin
      check("aluoperation", 64'(aluoperation), 64'(eop));
      check("illegal", 64'(illegal), 64'(eop == 15));
      check("stall", 64'(stall), 64'(phase == 1 || (phase == 0 && valid && eop == 14 && !reset)));
      check("mdu_done", 64'(mdu_done), 64'(phase == 2));
      check("mdu_result", 64'(mdu_result), 64'(m_res));
    end
    if (reset) begin
      phase = 0;
      m_res = 32'd0;
    end else begin
      case (phase)
        0: if (valid && eop == 14) begin
          if (is_special(func3, src_a, src_b)) begin
            phase = 2;
            m_res = mdu_ref(func3, src_a, src_b);
          end else begin
            phase   = 1;
            done_at = cyc + WIDTH + 1;
            pending = mdu_ref(func3, src_a, src_b);
          end
        end
        1: begin
          if (!valid) phase = 0;
          else if (cyc + 1 == done_at) begin
            phase = 2;
            m_res = pending;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
    aluop = ao; func3 = f3; func7 = f7; src_a = a; src_b = b; valid = 1'b1;
  endtask

  // Presents one instruction, holds it through any stall, returns result and latency.
  task automatic run(input logic [2:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output int lat);
    set_instr(ao, f3, f7, a, b);
    lat = 0;
    if (exp_op(ao, f3, f7) == 14) begin
      while (lat < 60) begin
        tick();
        lat++;
        if (mdu_done) break;
      end
      check("done_seen", 64'(mdu_done), 64'd1);
    end else begin
      tick();
    end
    res = mdu_result;
    valid = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    int          seen;
    logic [2:0]  ao;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) tick();
    started = 1'b1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(mdu_done), 64'd0);
    check("rst_result", 64'(mdu_result), 64'd0);
    reset = 1'b0;
    tick();

    set_instr(3'b111, 3'b000, 7'h00, 32'd1, 32'd2);
    #1;
    check("r_add_op", 64'(aluoperation), 64'd0);
    check("r_add_stall", 64'(stall), 64'd0);
    check("r_add_illegal", 64'(illegal), 64'd0);
    func7 = 7'h20;
    #1;
    check("r_sub_op", 64'(aluoperation), 64'd1);
    check("r_sub_illegal", 64'(illegal), 64'd0);
    tick();
    valid = 1'b0;

    run(3'b111, 3'd0, 7'h01, 32'd7, 32'd6, res, lat);
    check("mul_7x6", 64'(res), 64'd42);
    check("mul_latency", 64'(lat), 64'd33);
    tick();
    run(3'b111, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhu_ff", 64'(res), 64'hFFFF_FFFE);
    tick();

`ifdef ALU_CONTROL_DIV_EN
    run(3'b111, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("div_m7_2", 64'(res), 64'hFFFF_FFFD);
    check("div_latency", 64'(lat), 64'd33);
    run(3'b111, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("rem_m7_2", 64'(res), 64'hFFFF_FFFF);
    run(3'b111, 3'd5, 7'h01, 32'd5, 32'd0, res, lat);
    check("divu_5_0", 64'(res), 64'hFFFF_FFFF);
    check("divu_zero_latency", 64'(lat), 64'd1);
    run(3'b111, 3'd7, 7'h01, 32'd5, 32'd0, res, lat);
    check("remu_5_0", 64'(res), 64'd5);
    run(3'b111, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("div_ovf", 64'(res), 64'h8000_0000);
    check("div_ovf_latency", 64'(lat), 64'd1);
    tick();
`else
    set_instr(3'b111, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
    #1;
    check("div_off_op", 64'(aluoperation), 64'd15);
    check("div_off_illegal", 64'(illegal), 64'd1);
    check("div_off_stall", 64'(stall), 64'd0);
    tick();
    valid = 1'b0;
`endif

    // Abort: valid dropped five cycles into a multiply.
    held = mdu_result;
    set_instr(3'b111, 3'd0, 7'h01, 32'd9, 32'd9);
    repeat (5) tick();
    valid = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (mdu_done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_result_held", 64'(mdu_result), 64'(held));

    // Reset in the middle of a multiply.
    set_instr(3'b111, 3'd0, 7'h01, 32'd3, 32'd5);
    repeat (10) tick();
    reset = 1'b1;
    valid = 1'b0;
    tick();
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_done", 64'(mdu_done), 64'd0);
    check("midrst_result", 64'(mdu_result), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin ao = 3'b111; f7 = 7'h01; end
        1: begin ao = 3'b111; f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20; end
        2: begin ao = 3'($urandom); f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h20 & 7'($urandom); end
        default: begin ao = 3'b111; f7 = 7'($urandom); end
      endcase
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run(ao, f3, f7, a, b, res, lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
